udc_mod_counter: RTL and testbench

Parametrised up/down modulo counter, the successor to the board-level 4-bit up/down counter. Adds configurable width and modulus, wrap or saturate mode, synchronous load and clear, carry/borrow pulses, and on-chip synchronisation of the push-button `up`/`down` inputs with optional edge (one-step-per-press) counting. It sits between the debounced board buttons and the 7-segment/LED output logic. Direction is shown on the 7-segment display as 'U' or 'd'.

---
 rtl/udc_pkg.sv | 15 +
 rtl/udc_sync_edge.sv | 28 ++
 rtl/udc_mod_counter.sv | 111 +++++++++++
 tb/tb_udc_mod_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared constants and parameter checks for the up/down modulo counter.
package udc_pkg;

    localparam logic [6:0] SEG_UP    = 7'b0111110;
    localparam logic [6:0] SEG_DOWN  = 7'b1011110;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Range 0..MODULUS-1 must fit in WIDTH bits and hold at least two values.
    function automatic bit modulus_ok(input int width, input int modulus);
        longint span;
        span = longint'(1) << width;
        return (width >= 1) && (width <= 31) && (modulus >= 2) && (longint'(modulus) <= span);
    endfunction

endpackage

// File: rtl/udc_sync_edge.sv
// Two-flop synchroniser plus history flop for one asynchronous button.
module sync_edge #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic ev_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge mode gives one request per press; level mode one per held cycle.
    assign ev_o = EDGE_MODE ? (s2_q & ~s3_q) : s2_q;

endmodule

// File: rtl/udc_mod_counter.sv
// Up/down modulo counter with wrap/saturate ends, load/clear and direction glyph.
module udc_mod_counter
    import udc_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter bit SATURATE  = 1'b0,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [6:0]       seg,
    output logic             carry,
    output logic             borrow
);

    generate
        if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
            $error("udc_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // One extra bit keeps MODULUS-1 representable when MODULUS = 2**WIDTH.
    localparam logic [WIDTH:0] TERM_C = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_C  = {{WIDTH{1'b0}}, 1'b1};

    logic             ev_up, ev_dn;
    logic [WIDTH-1:0] count_q, count_d;
    logic [6:0]       seg_q, seg_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:0]   count_ext, load_ext, up_sum, dn_diff;

    sync_edge #(.EDGE_MODE(EDGE_MODE)) u_sync_up (
        .clk   (clk),
        .reset (reset),
        .btn_i (up),
        .ev_o  (ev_up)
    );

    sync_edge #(.EDGE_MODE(EDGE_MODE)) u_sync_dn (
        .clk   (clk),
        .reset (reset),
        .btn_i (down),
        .ev_o  (ev_dn)
    );

    always_comb begin
        count_ext = {1'b0, count_q};
        load_ext  = {1'b0, load_val};
        up_sum    = count_ext + ONE_C;
        dn_diff   = count_ext - ONE_C;
        count_d   = count_q;
        seg_d     = EDGE_MODE ? seg_q : SEG_BLANK;
        carry_d   = 1'b0;
        borrow_d  = 1'b0;

        if (clr) begin
            count_d = '0;
            seg_d   = SEG_BLANK;
        end else if (load) begin
            count_d = (load_ext > TERM_C) ? TERM_C[WIDTH-1:0] : load_val;
            seg_d   = SEG_BLANK;
        end else if (ev_up && ev_dn) begin
            count_d = '0;
            seg_d   = SEG_BLANK;
        end else if (ev_up) begin
            seg_d = SEG_UP;
            if (count_ext < TERM_C) begin
                count_d = up_sum[WIDTH-1:0];
            end else begin
                carry_d = 1'b1;
                if (!SATURATE) count_d = '0;
            end
        end else if (ev_dn) begin
            seg_d = SEG_DOWN;
            if (count_ext != '0) begin
                count_d = dn_diff[WIDTH-1:0];
            end else begin
                borrow_d = 1'b1;
                if (!SATURATE) count_d = TERM_C[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            seg_q    <= SEG_BLANK;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            seg_q    <= seg_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count  = count_q;
    assign seg    = seg_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_udc_mod_counter.sv
// Directed bench for udc_mod_counter: three MODULUS=10 variants (wrap/edge, wrap/level, saturate/edge).
module tb_udc_mod_counter;

    localparam logic [6:0] SEG_U = 7'b0111110;
    localparam logic [6:0] SEG_D = 7'b1011110;

    logic       clk = 1'b0;
    logic       reset, clr, load;
    logic [3:0] load_val;
    logic       up_a, down_a, up_b, down_b, up_c, down_c;
    logic [3:0] count_a, count_b, count_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       carry_a, carry_b, carry_c;
    logic       borrow_a, borrow_b, borrow_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    udc_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .EDGE_MODE(1'b1)) dut_a (
        .clk(clk), .reset(reset), .up(up_a), .down(down_a), .clr(clr), .load(load),
        .load_val(load_val), .count(count_a), .seg(seg_a), .carry(carry_a), .borrow(borrow_a)
    );

    udc_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .EDGE_MODE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .up(up_b), .down(down_b), .clr(clr), .load(load),
        .load_val(load_val), .count(count_b), .seg(seg_b), .carry(carry_b), .borrow(borrow_b)
    );

    udc_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .EDGE_MODE(1'b1)) dut_c (
        .clk(clk), .reset(reset), .up(up_c), .down(down_c), .clr(clr), .load(load),
        .load_val(load_val), .count(count_c), .seg(seg_c), .carry(carry_c), .borrow(borrow_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] v);
        load_val = v;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
    endtask

    task automatic pulse_up_a();
        up_a = 1'b1;
        tick(1);
        up_a = 1'b0;
        tick(2);
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        up_a = 1'b0; down_a = 1'b0; up_b = 1'b0; down_b = 1'b0; up_c = 1'b0; down_c = 1'b0;

        tick(3);
        check("rst_count_a", count_a, 0);
        check("rst_seg_a", seg_a, 0);
        check("rst_carry_a", carry_a, 0);
        check("rst_borrow_a", borrow_a, 0);
        check("rst_count_b", count_b, 0);
        check("rst_count_c", count_c, 0);
        reset = 1'b1;
        tick(2);

        // single one-cycle up pulse, step lands two edges after sampling
        up_a = 1'b1;
        tick(1);
        up_a = 1'b0;
        tick(1);
        check("step_not_yet", count_a, 0);
        tick(1);
        check("step_count", count_a, 1);
        check("step_seg", seg_a, SEG_U);
        check("step_carry", carry_a, 0);
        tick(1);
        check("step_seg_hold", seg_a, SEG_U);
        check("step_count_hold", count_a, 1);

        // held button in edge mode counts once
        pulse_clr();
        check("clr_count", count_a, 0);
        check("clr_seg", seg_a, 0);
        up_a = 1'b1;
        tick(20);
        up_a = 1'b0;
        tick(3);
        check("held_edge_count", count_a, 1);

        // held button in level mode steps every cycle, wrapping 9->0 with carry
        pulse_clr();
        up_b = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check("held_lvl_count", count_b, (k < 3) ? 0 : (k - 2) % 10);
            check("held_lvl_carry", carry_b, (k == 12) ? 1 : 0);
        end
        check("held_lvl_seg", seg_b, SEG_U);
        up_b = 1'b0;
        tick(1);
        check("lvl_tail_count", count_b, 9);
        tick(1);
        check("lvl_wrap_count", count_b, 0);
        check("lvl_wrap_carry", carry_b, 1);
        tick(2);
        check("lvl_idle_count", count_b, 0);
        check("lvl_idle_carry", carry_b, 0);
        check("lvl_idle_seg", seg_b, 0);

        // down at zero: wrap versus saturate
        pulse_clr();
        down_a = 1'b1; down_c = 1'b1;
        tick(1);
        down_a = 1'b0; down_c = 1'b0;
        tick(2);
        check("wrap_dn_count", count_a, 9);
        check("wrap_dn_borrow", borrow_a, 1);
        check("wrap_dn_seg", seg_a, SEG_D);
        check("sat_dn_count", count_c, 0);
        check("sat_dn_borrow", borrow_c, 1);
        check("sat_dn_seg", seg_c, SEG_D);
        tick(1);
        check("wrap_borrow_end", borrow_a, 0);
        check("sat_borrow_end", borrow_c, 0);
        check("wrap_dn_stable", count_a, 9);

        // up at MODULUS-1: wrap versus saturate
        do_load(4'd9);
        check("ld9_count_c", count_c, 9);
        check("ld9_seg_c", seg_c, 0);
        up_a = 1'b1; up_c = 1'b1;
        tick(1);
        up_a = 1'b0; up_c = 1'b0;
        tick(2);
        check("wrap_up_count", count_a, 0);
        check("wrap_up_carry", carry_a, 1);
        check("sat_up_count", count_c, 9);
        check("sat_up_carry", carry_c, 1);
        check("sat_up_seg", seg_c, SEG_U);

        // simultaneous up and down clear the count with no pulses
        do_load(4'd5);
        check("ld5_count", count_a, 5);
        pulse_up_a();
        check("pre_sim_count", count_a, 6);
        up_a = 1'b1; down_a = 1'b1;
        tick(1);
        up_a = 1'b0; down_a = 1'b0;
        tick(2);
        check("sim_count", count_a, 0);
        check("sim_seg", seg_a, 0);
        check("sim_carry", carry_a, 0);
        check("sim_borrow", borrow_a, 0);

        // clear beats load
        do_load(4'd3);
        check("ld3_count", count_a, 3);
        load_val = 4'd8; load = 1'b1; clr = 1'b1;
        tick(1);
        load = 1'b0; clr = 1'b0;
        check("clr_over_load", count_a, 0);

        // load clamps to MODULUS-1 and blanks seg
        pulse_up_a();
        check("pre_clamp_seg", seg_a, SEG_U);
        do_load(4'd14);
        check("clamp14_count", count_a, 9);
        check("clamp14_seg", seg_a, 0);
        check("clamp14_count_c", count_c, 9);
        do_load(4'd10);
        check("clamp10_count", count_a, 9);

        // asynchronous reset mid-count, then a button held through release
        do_load(4'd6);
        pulse_up_a();
        check("pre_rst_count", count_a, 7);
        check("pre_rst_seg", seg_a, SEG_U);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", count_a, 0);
        check("async_rst_seg", seg_a, 0);
        up_a = 1'b1;
        tick(2);
        check("rst_held_count", count_a, 0);
        check("rst_held_seg", seg_a, 0);
        reset = 1'b1;
        tick(2);
        check("rel_not_yet", count_a, 0);
        tick(1);
        check("rel_step_count", count_a, 1);
        check("rel_step_seg", seg_a, SEG_U);
        up_a = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
